// File: rtl/fixed_linear_bias_add.sv
// fixed_linear_bias_add
// Two-stage pipelined bias add for fixed-point matmul results.
//   stage 1: sum = data_in + (bias aligned to the data_in fraction point)
//   stage 2: requantise to the output fraction point (floor) and narrow
// A beat counter tags every BIAS_DEPTH-th accepted beat as the last beat of
// an output row; the tag travels with the data.
// Optional build macro: FIXED_LINEAR_BIAS_ADD_SATURATE_EN
//   defined   -> narrowing clamps to the signed output range
//   undefined -> narrowing keeps the low output bits (two's-complement wrap)

module fixed_linear_bias_add #(
  parameter int DATA_IN_0_PRECISION_0  = 32,
  parameter int DATA_IN_0_PRECISION_1  = 8,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PRECISION_0 = 16,
  parameter int DATA_OUT_0_PRECISION_1 = 3,
  parameter int PARALLELISM            = 1,
  parameter int BIAS_DEPTH             = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [PARALLELISM*DATA_IN_0_PRECISION_0-1:0]      data_in_0,
  input  logic                                              data_in_0_valid,
  output logic                                              data_in_0_ready,
  input  logic [PARALLELISM*BIAS_PRECISION_0-1:0]           bias,
  input  logic                                              bias_valid,
  output logic                                              bias_ready,
  output logic [PARALLELISM*DATA_OUT_0_PRECISION_0-1:0]     data_out_0,
  output logic                                              data_out_0_valid,
  input  logic                                              data_out_0_ready,
  output logic                                              data_out_0_last
);

  localparam int DIN_W      = DATA_IN_0_PRECISION_0;
  localparam int SUM_W      = DIN_W + 1;
  localparam int BIAS_W     = BIAS_PRECISION_0;
  localparam int DOUT_W     = DATA_OUT_0_PRECISION_0;
  localparam int BIAS_SHIFT = DATA_IN_0_PRECISION_1 - BIAS_PRECISION_1;
  localparam int OUT_SHIFT  = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
  localparam int CNT_W      = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIAS_DEPTH - 1);
`ifdef FIXED_LINEAR_BIAS_ADD_SATURATE_EN
  localparam int HI_W       = SUM_W - DOUT_W + 1;
`endif

  logic                            s1_valid_q, s1_valid_d;
  logic                            s1_last_q,  s1_last_d;
  logic [PARALLELISM*SUM_W-1:0]    s1_sum_q,   s1_sum_d;
  logic                            s2_valid_q, s2_valid_d;
  logic                            s2_last_q,  s2_last_d;
  logic [PARALLELISM*DOUT_W-1:0]   s2_data_q,  s2_data_d;
  logic [CNT_W-1:0]                cnt_q,      cnt_d;

  logic s2_can_load;
  logic s1_can_load;
  logic s1_advance;
  logic accept;

  // Requantise one stage-1 sum: floor shift to the output fraction point, then narrow.
  function automatic logic [DOUT_W-1:0] narrow_lane(input logic signed [SUM_W-1:0] sum);
`ifdef FIXED_LINEAR_BIAS_ADD_SATURATE_EN
    logic signed [SUM_W-1:0] shifted;
    logic [HI_W-1:0]         hi;
    shifted = sum >>> OUT_SHIFT;
    hi      = shifted[SUM_W-1:DOUT_W-1];
    // In range only when every bit above the output sign bit matches it.
    if ((&hi) || !(|hi)) begin
      return shifted[DOUT_W-1:0];
    end else if (shifted[SUM_W-1]) begin
      return {1'b1, {(DOUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DOUT_W-1){1'b1}}};
    end
`else
    return DOUT_W'(sum >>> OUT_SHIFT);
`endif
  endfunction

  // Handshake: a stage loads when empty or when its successor takes its beat this cycle.
  // Each input ready also requires the other stream's valid so neither is consumed alone.
  assign s2_can_load     = !s2_valid_q || data_out_0_ready;
  assign s1_can_load     = !s1_valid_q || s2_can_load;
  assign s1_advance      = s1_valid_q && s2_can_load;
  assign accept          = data_in_0_valid && bias_valid && s1_can_load;
  assign data_in_0_ready = s1_can_load && bias_valid;
  assign bias_ready      = s1_can_load && data_in_0_valid;

  // Beat position within the current output row.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Stage 1: align the bias to the data_in fraction point and add at one extra bit of width.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_sum_d   = s1_sum_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (cnt_q == CNT_LAST);
      for (int i = 0; i < PARALLELISM; i++) begin
        s1_sum_d[i*SUM_W +: SUM_W] =
          SUM_W'($signed(data_in_0[i*DIN_W +: DIN_W])) +
          (SUM_W'($signed(bias[i*BIAS_W +: BIAS_W])) <<< BIAS_SHIFT);
      end
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: requantise and narrow; contents hold while the consumer stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_data_d  = s2_data_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_last_d  = s1_last_q;
      for (int i = 0; i < PARALLELISM; i++) begin
        s2_data_d[i*DOUT_W +: DOUT_W] = narrow_lane(s1_sum_q[i*SUM_W +: SUM_W]);
      end
    end else if (data_out_0_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline and counter registers; reset drops any in-flight beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out_0       = s2_data_q;
  assign data_out_0_valid = s2_valid_q;
  assign data_out_0_last  = s2_last_q;

endmodule

// File: tb/tb_fixed_linear_bias_add.sv
// Bench for fixed_linear_bias_add: two lanes, BIAS_DEPTH=4, other parameters default.
// Reference model: plain integer arithmetic per lane plus a queue of expected beats.

module tb_fixed_linear_bias_add;

  localparam int P     = 2;
  localparam int DW    = 32;
  localparam int BW    = 16;
  localparam int OW    = 16;
  localparam int DEPTH = 4;
`ifdef FIXED_LINEAR_BIAS_ADD_SATURATE_EN
  localparam logic [OW-1:0] BIG_EXP = 16'h7FFF;
`else
  localparam logic [OW-1:0] BIG_EXP = 16'hFFF0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [P*DW-1:0] din;
  logic            din_v, din_r;
  logic [P*BW-1:0] bias;
  logic            bias_v, bias_r;
  logic [P*OW-1:0] dout;
  logic            dout_v, dout_r, dout_last;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [P*OW-1:0] data;
    logic            last;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            e_mon;
  int              beat_cnt = 0;
  logic            prev_stall = 1'b0;
  logic [P*OW-1:0] prev_data;
  logic            prev_last;

  fixed_linear_bias_add #(
    .PARALLELISM (P),
    .BIAS_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (din),
    .data_in_0_valid  (din_v),
    .data_in_0_ready  (din_r),
    .bias             (bias),
    .bias_valid       (bias_v),
    .bias_ready       (bias_r),
    .data_out_0       (dout),
    .data_out_0_valid (dout_v),
    .data_out_0_ready (dout_r),
    .data_out_0_last  (dout_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Value of one lane: bias scaled from 3 to 8 fraction bits, sum floored to 3 fraction bits.
  function automatic logic [OW-1:0] ref_lane(input logic [DW-1:0] d, input logic [BW-1:0] b);
    longint s, q;
    s = longint'($signed(d)) + longint'($signed(b)) * 32;
    q = s >>> 5;
`ifdef FIXED_LINEAR_BIAS_ADD_SATURATE_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[OW-1:0];
  endfunction

  function automatic logic [P*OW-1:0] ref_beat(input logic [P*DW-1:0] d, input logic [P*BW-1:0] b);
    logic [P*OW-1:0] r;
    for (int i = 0; i < P; i++) r[i*OW +: OW] = ref_lane(d[i*DW +: DW], b[i*BW +: BW]);
    return r;
  endfunction

  function automatic logic [P*DW-1:0] rand_din();
    logic [P*DW-1:0] r;
    for (int i = 0; i < P; i++) begin
      case ($urandom % 8)
        0:       r[i*DW +: DW] = 32'h7FFF_FFFF;
        1:       r[i*DW +: DW] = 32'h8000_0000;
        2:       r[i*DW +: DW] = 32'(($urandom % 4096)) - 32'd2048;
        default: r[i*DW +: DW] = $urandom;
      endcase
    end
    return r;
  endfunction

  function automatic logic [P*BW-1:0] rand_bias();
    logic [P*BW-1:0] r;
    for (int i = 0; i < P; i++) r[i*BW +: BW] = 16'($urandom);
    return r;
  endfunction

  // Scoreboard: inputs are stable from just after the rising edge until the next one,
  // so values seen at the falling edge are the ones the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (dout_v && dout_r) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_queue_size", 64'(exp_q.size()), 64'd1);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_data", 64'(dout), 64'(e_mon.data));
          chk("out_last", 64'(dout_last), 64'(e_mon.last));
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(dout_v), 64'd1);
        chk("hold_data", 64'(dout), 64'(prev_data));
        chk("hold_last", 64'(dout_last), 64'(prev_last));
      end
      prev_stall = dout_v && !dout_r;
      prev_data  = dout;
      prev_last  = dout_last;
      if (din_v && !bias_v) chk("din_ready_without_bias", 64'(din_r), 64'd0);
      if (bias_v && !din_v) chk("bias_ready_without_din", 64'(bias_r), 64'd0);
      if (din_v && bias_v) chk("ready_pair_equal", 64'(din_r), 64'(bias_r));
      if (din_v && din_r && bias_v && bias_r) begin
        e_mon.data = ref_beat(din, bias);
        e_mon.last = (beat_cnt == DEPTH - 1);
        exp_q.push_back(e_mon);
        beat_cnt = (beat_cnt + 1) % DEPTH;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat into an empty pipeline; pins latency and a literal result.
  task automatic send_one(input string name, input logic [DW-1:0] d, input logic [BW-1:0] b,
                          input logic [OW-1:0] req);
    din    = {P{d}};
    bias   = {P{b}};
    din_v  = 1'b1;
    bias_v = 1'b1;
    dout_r = 1'b1;
    @(negedge clk);
    chk({name, "_accepted"}, 64'(din_r && bias_r), 64'd1);
    step();
    din_v  = 1'b0;
    bias_v = 1'b0;
    @(negedge clk);
    chk({name, "_valid_after_1"}, 64'(dout_v), 64'd0);
    @(negedge clk);
    chk({name, "_valid_after_2"}, 64'(dout_v), 64'd1);
    chk({name, "_lane0"}, 64'(dout[OW-1:0]), 64'(req));
    chk({name, "_lane1"}, 64'(dout[2*OW-1:OW]), 64'(req));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    din    = '0;
    bias   = '0;
    din_v  = 1'b0;
    bias_v = 1'b0;
    dout_r = 1'b1;
    repeat (2) step();
    chk("reset_data", 64'(dout), 64'd0);
    chk("reset_valid", 64'(dout_v), 64'd0);
    chk("reset_last", 64'(dout_last), 64'd0);
    rst = 1'b1;
    step();

    send_one("plus_one", 32'h0000_0100, 16'h0008, 16'h0010);
    send_one("minus_one", 32'hFFFF_FF00, 16'hFFF8, 16'hFFF0);
    send_one("large", 32'h7FFF_FE00, 16'h0000, BIG_EXP);

    // Stream, then stall the consumer for 3 cycles with both stages full.
    din_v  = 1'b1;
    bias_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din  = rand_din();
      bias = rand_bias();
      step();
    end
    dout_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din  = rand_din();
      bias = rand_bias();
      @(negedge clk);
      chk("stall_din_ready", 64'(din_r), 64'd0);
      chk("stall_bias_ready", 64'(bias_r), 64'd0);
      chk("stall_out_valid", 64'(dout_v), 64'd1);
      step();
    end
    dout_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din  = rand_din();
      bias = rand_bias();
      step();
    end
    din_v  = 1'b0;
    bias_v = 1'b0;
    repeat (4) step();
    chk("stall_drain_queue", 64'(exp_q.size()), 64'd0);

    // Reset pulsed with beats in flight.
    din_v  = 1'b1;
    bias_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din  = rand_din();
      bias = rand_bias();
      step();
    end
    rst = 1'b0;
    #1;
    chk("midreset_data", 64'(dout), 64'd0);
    chk("midreset_valid", 64'(dout_v), 64'd0);
    chk("midreset_last", 64'(dout_last), 64'd0);
    exp_q.delete();
    beat_cnt = 0;
    din_v    = 1'b0;
    bias_v   = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("post_reset_valid", 64'(dout_v), 64'd0);

    // data valid without bias: nothing may be accepted.
    din   = rand_din();
    din_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_bias_din_ready", 64'(din_r), 64'd0);
      chk("no_bias_out_valid", 64'(dout_v), 64'd0);
      step();
    end
    din_v = 1'b0;

    // 8 back-to-back beats: last on output beats 3 and 7, no bubbles.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        din    = rand_din();
        bias   = rand_bias();
        din_v  = 1'b1;
        bias_v = 1'b1;
      end else begin
        din_v  = 1'b0;
        bias_v = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        chk("b2b_din_ready", 64'(din_r), 64'd1);
        chk("b2b_bias_ready", 64'(bias_r), 64'd1);
      end
      if (i >= 2) begin
        chk("b2b_out_valid", 64'(dout_v), 64'd1);
        chk("b2b_out_last", 64'(dout_last), 64'(((i - 2) % 4) == 3));
      end
      step();
    end
    chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      din    = rand_din();
      bias   = rand_bias();
      din_v  = ($urandom % 4) != 0;
      bias_v = ($urandom % 4) != 0;
      dout_r = ($urandom % 10) < 7;
      step();
    end
    din_v  = 1'b0;
    bias_v = 1'b0;
    dout_r = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("final_drain_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
